// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, controller states
// and the word-crossing rule used to decide when an access must be split.
package lsu_pkg;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b10;

  typedef enum logic [2:0] {IDLE, RD0, RD1, RESP, ST} state_t;

  // An access is split only when it crosses a 32-bit word; mode 11 behaves as word.
  function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] off);
    logic r;
    case (mode)
      MODE_BYTE: r = 1'b0;
      MODE_HALF: r = (off == 2'b11);
      default:   r = (off != 2'b00);
    endcase
    return r;
  endfunction

  function automatic logic [1:0] last_byte_idx(input logic [1:0] mode);
    return (mode == MODE_HALF) ? 2'd1 : 2'd3;
  endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian byte extraction from a 64-bit read window followed by
// zero or sign extension to 32 bits.
module load_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_mode,
  input  logic        i_unsigned,
  input  logic [63:0] i_window,
  output logic [31:0] o_result
);

  logic [31:0]        w_shift;
  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;

  assign w_shift = 32'(i_window >> {i_off, 3'b000});
  assign w_byte  = w_shift[7:0];
  assign w_half  = w_shift[15:0];

  always_comb begin
    o_result = w_shift;
    case (i_mode)
      MODE_BYTE: begin
        if (i_unsigned) o_result = {24'd0, w_shift[7:0]};
        else            o_result = 32'(w_byte);
      end
      MODE_HALF: begin
        if (i_unsigned) o_result = {16'd0, w_shift[15:0]};
        else            o_result = 32'(w_half);
      end
      default: o_result = w_shift;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: word-wide reads with in-unit alignment (two reads for a
// word-crossing load) and byte-by-byte writes for word-crossing stores.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_mode,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic [31:0] addr,
  output logic [1:0]  mem_mode,
  output logic        mem_unsigned,
  output logic [31:0] st_data,
  output logic        st_en,
  input  logic [31:0] ld_data
);

  state_t      r_state, w_next;
  logic [1:0]  r_mode, r_off, r_cnt, w_cnt_nx;
  logic        r_unsigned, r_mis;
  logic [31:0] r_wdata, r_buf, r_addr, r_st_data;
  logic [1:0]  r_mem_mode;
  logic        r_mem_unsigned, r_st_en;
  logic        w_req_mis, w_last_wr;
  logic [63:0] w_window;
  logic [31:0] w_align;

  assign w_req_mis = is_misaligned(req_mode, req_addr[1:0]);
  assign w_last_wr = !r_mis || (r_cnt == last_byte_idx(r_mode));
  assign w_cnt_nx  = r_cnt + 2'd1;
  // A split load holds the low word in r_buf while the high word arrives.
  assign w_window  = r_mis ? {ld_data, r_buf} : {32'd0, ld_data};

  load_align u_align (
    .i_off      (r_off),
    .i_mode     (r_mode),
    .i_unsigned (r_unsigned),
    .i_window   (w_window),
    .o_result   (w_align)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = req_store ? ST : RD0;
      RD0:     w_next = r_mis ? RD1 : RESP;
      RD1:     w_next = RESP;
      RESP:    w_next = IDLE;
      ST:      if (w_last_wr) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign req_ready       = (r_state == IDLE);
  assign resp_valid      = (r_state == RESP) || ((r_state == ST) && w_last_wr);
  assign resp_misaligned = resp_valid && r_mis;
  assign resp_rdata      = (r_state == RESP) ? w_align : 32'd0;
  assign addr            = r_addr;
  assign mem_mode        = r_mem_mode;
  assign mem_unsigned    = r_mem_unsigned;
  assign st_data         = r_st_data;
  assign st_en           = r_st_en;

  always_ff @(posedge clock_i) begin
    if (reset_ni) begin
      r_state        <= IDLE;
      r_mode         <= 2'd0;
      r_off          <= 2'd0;
      r_cnt          <= 2'd0;
      r_unsigned     <= 1'b0;
      r_mis          <= 1'b0;
      r_wdata        <= 32'd0;
      r_buf          <= 32'd0;
      r_addr         <= 32'd0;
      r_st_data      <= 32'd0;
      r_mem_mode     <= 2'd0;
      r_mem_unsigned <= 1'b0;
      r_st_en        <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (req_valid) begin
          r_mode     <= req_mode;
          r_off      <= req_addr[1:0];
          r_unsigned <= req_unsigned;
          r_mis      <= w_req_mis;
          r_wdata    <= req_wdata;
          r_cnt      <= 2'd0;
          if (req_store) begin
            r_addr         <= req_addr;
            r_mem_mode     <= w_req_mis ? MODE_BYTE : req_mode;
            r_mem_unsigned <= 1'b0;
            r_st_data      <= w_req_mis ? {24'd0, req_wdata[7:0]} : req_wdata;
            r_st_en        <= 1'b1;
          end else begin
            r_addr         <= {req_addr[31:2], 2'b00};
            r_mem_mode     <= MODE_WORD;
            r_mem_unsigned <= 1'b1;
          end
        end
        RD0: if (r_mis) r_addr <= r_addr + 32'd4;
        RD1: r_buf <= ld_data;
        ST: begin
          if (w_last_wr) begin
            r_st_en <= 1'b0;
          end else begin
            r_cnt     <= w_cnt_nx;
            r_addr    <= r_addr + 32'd1;
            r_st_data <= {24'd0, 8'(r_wdata >> {w_cnt_nx, 3'b000})};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases, randomized loads
// and stores against a byte-level memory model, reset abort and back-to-back.
module tb_load_store_unit;

  localparam int NC = 6;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]  req_mode;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misaligned;
  logic [31:0] resp_rdata;
  logic [31:0] addr, st_data;
  logic [1:0]  mem_mode;
  logic        mem_unsigned, st_en;
  logic [31:0] ld_data = 32'd0;

  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  logic        a_ready [0:NC];
  logic        a_rv    [0:NC];
  logic        a_mis   [0:NC];
  logic        a_sten  [0:NC];
  logic        a_uns   [0:NC];
  logic [1:0]  a_mode  [0:NC];
  logic [31:0] a_rdata [0:NC];
  logic [31:0] a_addr  [0:NC];
  logic [31:0] a_sdata [0:NC];

  load_store_unit dut (
    .clock_i         (clk),
    .reset_ni        (reset_ni),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_store       (req_store),
    .req_mode        (req_mode),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .addr            (addr),
    .mem_mode        (mem_mode),
    .mem_unsigned    (mem_unsigned),
    .st_data         (st_data),
    .st_en           (st_en),
    .ld_data         (ld_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read data memory, 256 words, address bits above 9 ignored.
  always @(posedge clk) ld_data <= mem[addr[9:2]];

  function automatic int nbytes(input logic [1:0] md);
    return (md == 2'b00) ? 1 : (md == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic exp_mis(input logic [1:0] md, input logic [31:0] a);
    return (int'(a[1:0]) + nbytes(md)) > 4;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return w[int'(a[1:0]) * 8 +: 8];
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] md, input logic un, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(md);
    v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = byte_at(a + 32'(i));
    if (!un && n < 4 && v[8*n-1])
      for (int j = 8*n; j < 32; j++) v[j] = 1'b1;
    return v;
  endfunction

  task automatic sample(input int c);
    a_ready[c] = req_ready;
    a_rv[c]    = resp_valid;
    a_mis[c]   = resp_misaligned;
    a_rdata[c] = resp_rdata;
    a_addr[c]  = addr;
    a_mode[c]  = mem_mode;
    a_uns[c]   = mem_unsigned;
    a_sten[c]  = st_en;
    a_sdata[c] = st_data;
  endtask

  // Issue one request from idle, scramble the request inputs after accept,
  // and record the outputs for NC cycles after the accept edge.
  task automatic run_op(input logic st, input logic [1:0] md, input logic un,
                        input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    sample(0);
    req_valid = 1'b1; req_store = st; req_mode = md; req_unsigned = un;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_store = 1'($urandom); req_mode = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= NC; c++) begin
      @(negedge clk);
      sample(c);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    checks++; if (st_en !== 1'b0) begin errors++; $display("FAIL reset_st_en got %b exp 0", st_en); end
    checks++; if (addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", addr); end
    checks++; if ({mem_mode, mem_unsigned} !== 3'd0) begin errors++; $display("FAIL reset_mode got %b exp 000", {mem_mode, mem_unsigned}); end
    checks++; if (st_data !== 32'd0) begin errors++; $display("FAIL reset_st_data got %h exp 0", st_data); end
    checks++; if ({resp_rdata, resp_misaligned} !== 33'd0) begin errors++; $display("FAIL reset_resp got %h exp 0", {resp_rdata, resp_misaligned}); end
  endtask

  task automatic test_directed_loads();
    mem[64] = 32'hDEADBEEF;
    run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    checks++; if (a_addr[1] !== 32'h100) begin errors++; $display("FAIL lw_addr got %h exp 00000100", a_addr[1]); end
    checks++; if (a_mode[1] !== 2'b10) begin errors++; $display("FAIL lw_mem_mode got %b exp 10", a_mode[1]); end
    checks++; if ({a_rv[1], a_rv[2], a_rv[3]} !== 3'b010) begin errors++; $display("FAIL lw_latency got %b exp 010", {a_rv[1], a_rv[2], a_rv[3]}); end
    checks++; if (a_rdata[2] !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h exp deadbeef", a_rdata[2]); end
    checks++; if (a_mis[2] !== 1'b0) begin errors++; $display("FAIL lw_mis got %b exp 0", a_mis[2]); end

    mem[64] = 32'h80FF0011;
    run_op(1'b0, 2'b00, 1'b0, 32'h103, 32'd0);
    checks++; if (a_rdata[2] !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata got %h exp ffffff80", a_rdata[2]); end
    run_op(1'b0, 2'b00, 1'b1, 32'h103, 32'd0);
    checks++; if (a_rdata[2] !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata got %h exp 00000080", a_rdata[2]); end

    mem[64] = 32'h44332211; mem[65] = 32'h88776655;
    run_op(1'b0, 2'b10, 1'b0, 32'h102, 32'd0);
    checks++; if ({a_addr[1], a_addr[2]} !== {32'h100, 32'h104}) begin errors++; $display("FAIL lw_mis_addrs got %h %h exp 00000100 00000104", a_addr[1], a_addr[2]); end
    checks++; if ({a_rv[2], a_rv[3], a_rv[4]} !== 3'b010) begin errors++; $display("FAIL lw_mis_latency got %b exp 010", {a_rv[2], a_rv[3], a_rv[4]}); end
    checks++; if (a_rdata[3] !== 32'h66554433) begin errors++; $display("FAIL lw_mis_rdata got %h exp 66554433", a_rdata[3]); end
    checks++; if (a_mis[3] !== 1'b1) begin errors++; $display("FAIL lw_mis_flag got %b exp 1", a_mis[3]); end

    mem[255] = 32'hAABBCCDD; mem[0] = 32'h11223344;
    run_op(1'b0, 2'b10, 1'b1, 32'hFFFFFFFE, 32'd0);
    checks++; if ({a_addr[1], a_addr[2]} !== {32'hFFFFFFFC, 32'h0}) begin errors++; $display("FAIL wrap_addrs got %h %h exp fffffffc 00000000", a_addr[1], a_addr[2]); end
    checks++; if (a_rdata[3] !== 32'h3344AABB) begin errors++; $display("FAIL wrap_rdata got %h exp 3344aabb", a_rdata[3]); end
  endtask

  task automatic test_directed_stores();
    run_op(1'b1, 2'b01, 1'b0, 32'h103, 32'h0000BEEF);
    checks++; if ({a_sten[1], a_sten[2], a_sten[3]} !== 3'b110) begin errors++; $display("FAIL sh_st_en got %b exp 110", {a_sten[1], a_sten[2], a_sten[3]}); end
    checks++; if ({a_addr[1], a_sdata[1]} !== {32'h103, 32'hEF}) begin errors++; $display("FAIL sh_wr0 got %h %h exp 00000103 000000ef", a_addr[1], a_sdata[1]); end
    checks++; if ({a_addr[2], a_sdata[2]} !== {32'h104, 32'hBE}) begin errors++; $display("FAIL sh_wr1 got %h %h exp 00000104 000000be", a_addr[2], a_sdata[2]); end
    checks++; if ({a_rv[1], a_rv[2], a_rv[3]} !== 3'b010) begin errors++; $display("FAIL sh_resp got %b exp 010", {a_rv[1], a_rv[2], a_rv[3]}); end
    checks++; if ({a_mode[1], a_mode[2]} !== 4'b0000) begin errors++; $display("FAIL sh_mode got %b exp 0000", {a_mode[1], a_mode[2]}); end

    run_op(1'b1, 2'b10, 1'b0, 32'h200, 32'h12345678);
    checks++; if ({a_sten[1], a_sten[2], a_rv[1]} !== 3'b101) begin errors++; $display("FAIL sw_en_resp got %b exp 101", {a_sten[1], a_sten[2], a_rv[1]}); end
    checks++; if ({a_addr[1], a_sdata[1], a_mode[1]} !== {32'h200, 32'h12345678, 2'b10}) begin errors++; $display("FAIL sw_write got %h %h %b exp 00000200 12345678 10", a_addr[1], a_sdata[1], a_mode[1]); end
  endtask

  task automatic test_random_loads();
    for (int t = 0; t < 40; t++) begin
      logic [1:0]  md;
      logic        un, mis, any_en;
      logic [31:0] a, ex;
      int          lat;
      md = 2'($urandom); un = 1'($urandom);
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 1023));
      mis = exp_mis(md, a); ex = exp_load(md, un, a); lat = mis ? 3 : 2;
      run_op(1'b0, md, un, a, $urandom);
      any_en = 1'b0;
      for (int c = 1; c <= NC; c++) begin
        any_en = any_en | a_sten[c];
        checks++; if (a_rv[c] !== (c == lat)) begin errors++; $display("FAIL rl_resp_valid a=%h md=%b c=%0d got %b exp %b", a, md, c, a_rv[c], (c == lat)); end
      end
      checks++; if (a_rdata[lat] !== ex) begin errors++; $display("FAIL rl_rdata a=%h md=%b un=%b got %h exp %h", a, md, un, a_rdata[lat], ex); end
      checks++; if (a_mis[lat] !== mis) begin errors++; $display("FAIL rl_mis a=%h md=%b got %b exp %b", a, md, a_mis[lat], mis); end
      checks++; if ({a_addr[1], a_mode[1], a_uns[1]} !== {a & 32'hFFFFFFFC, 2'b10, 1'b1}) begin errors++; $display("FAIL rl_req a=%h got %h %b %b", a, a_addr[1], a_mode[1], a_uns[1]); end
      if (mis) begin
        checks++; if (a_addr[2] !== (a & 32'hFFFFFFFC) + 32'd4) begin errors++; $display("FAIL rl_addr2 a=%h got %h", a, a_addr[2]); end
      end
      checks++; if (any_en !== 1'b0) begin errors++; $display("FAIL rl_st_en a=%h got %b exp 0", a, any_en); end
      checks++; if ({a_ready[0], a_ready[1], a_ready[lat + 1]} !== 3'b101) begin errors++; $display("FAIL rl_ready a=%h got %b exp 101", a, {a_ready[0], a_ready[1], a_ready[lat + 1]}); end
    end
  endtask

  task automatic test_random_stores();
    for (int t = 0; t < 30; t++) begin
      logic [1:0]  md, em;
      logic        mis;
      logic [31:0] a, wd, ea, ed;
      int          nw, k;
      md = 2'($urandom); wd = $urandom;
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 1023));
      mis = exp_mis(md, a); nw = mis ? nbytes(md) : 1;
      run_op(1'b1, md, 1'b0, a, wd);
      for (int c = 1; c <= NC; c++) begin
        checks++; if (a_sten[c] !== (c <= nw)) begin errors++; $display("FAIL rs_st_en a=%h md=%b c=%0d got %b exp %b", a, md, c, a_sten[c], (c <= nw)); end
        checks++; if (a_rv[c] !== (c == nw)) begin errors++; $display("FAIL rs_resp_valid a=%h md=%b c=%0d got %b exp %b", a, md, c, a_rv[c], (c == nw)); end
        if (c <= nw) begin
          k = c - 1;
          ea = mis ? a + 32'(k) : a;
          em = mis ? 2'b00 : md;
          ed = mis ? {24'd0, wd[8*k +: 8]} : wd;
          checks++; if ({a_addr[c], a_mode[c], a_sdata[c]} !== {ea, em, ed}) begin errors++; $display("FAIL rs_write a=%h md=%b k=%0d got %h %b %h exp %h %b %h", a, md, k, a_addr[c], a_mode[c], a_sdata[c], ea, em, ed); end
        end
      end
      checks++; if ({a_rdata[nw], a_mis[nw]} !== {32'd0, mis}) begin errors++; $display("FAIL rs_resp a=%h got %h %b exp 0 %b", a, a_rdata[nw], a_mis[nw], mis); end
      checks++; if (a_ready[nw + 1] !== 1'b1) begin errors++; $display("FAIL rs_ready a=%h got %b exp 1", a, a_ready[nw + 1]); end
    end
  endtask

  task automatic test_reset_mid();
    mem[64] = 32'h44332211; mem[65] = 32'h88776655;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_mode = 2'b10; req_unsigned = 1'b0; req_addr = 32'h102;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_ni = 1'b1;
    @(posedge clk); #1 reset_ni = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if ({resp_valid, st_en, req_ready} !== 3'b001) begin errors++; $display("FAIL rst_load c=%0d got %b exp 001", c, {resp_valid, st_en, req_ready}); end
    end

    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_mode = 2'b10; req_addr = 32'h101; req_wdata = 32'hA1B2C3D4;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (st_en !== 1'b1) begin errors++; $display("FAIL rst_store_pre got %b exp 1", st_en); end
    reset_ni = 1'b1;
    @(posedge clk); #1 reset_ni = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if ({resp_valid, st_en, req_ready} !== 3'b001) begin errors++; $display("FAIL rst_store c=%0d got %b exp 001", c, {resp_valid, st_en, req_ready}); end
    end

    mem[64] = 32'h0BADF00D;
    run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    checks++; if ({a_rv[2], a_rdata[2]} !== {1'b1, 32'h0BADF00D}) begin errors++; $display("FAIL rst_recover got %b %h exp 1 0badf00d", a_rv[2], a_rdata[2]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_ready, exp_rv, got_ready, got_rv;
    logic [31:0] r2, r5;
    mem[64] = 32'hCAFEF00D; mem[65] = 32'h13572468;
    exp_ready = 8'b11001001;
    exp_rv    = 8'b00100100;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_mode = 2'b10; req_unsigned = 1'b0; req_addr = 32'h100;
    for (int c = 0; c <= 7; c++) begin
      got_ready[c] = req_ready;
      got_rv[c]    = resp_valid;
      if (c == 2) r2 = resp_rdata;
      if (c == 5) r5 = resp_rdata;
      if (c == 1) req_addr = 32'h104;
      if (c == 4) req_valid = 1'b0;
      @(negedge clk);
    end
    checks++; if (got_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready got %b exp %b", got_ready, exp_ready); end
    checks++; if (got_rv !== exp_rv) begin errors++; $display("FAIL b2b_resp_valid got %b exp %b", got_rv, exp_rv); end
    checks++; if ({r2, r5} !== {32'hCAFEF00D, 32'h13572468}) begin errors++; $display("FAIL b2b_rdata got %h %h exp cafef00d 13572468", r2, r5); end
  endtask

  initial begin
    reset_ni = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_mode = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1 reset_ni = 1'b0;
    test_reset();
    test_directed_loads();
    test_directed_stores();
    test_random_loads();
    test_random_stores();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port: clock_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_ni  input  1  reset, synchronous and active-high; it acts at a rising edge of clock_i while high.
REQ-003 SHALL have port: req_valid  input  1  core presents a memory operation.
REQ-004 SHALL have port: req_ready  output  1  unit accepts; a transfer occurs at an edge where req_valid and req_ready are both high.
REQ-005 SHALL have port: req_store  input  1  1 = store, 0 = load.
REQ-006 SHALL have port: req_mode  input  2  operation size: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-007 SHALL have port: req_unsigned  input  1  load zero-extend (1) or sign-extend (0).
REQ-008 SHALL have port: req_addr  input  32  byte address.
REQ-009 SHALL have port: req_wdata  input  32  store data, right-justified.
REQ-010 SHALL have port: resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: resp_rdata  output  32  extended load result, valid with resp_valid; 0 for stores.
REQ-012 SHALL have port: resp_misaligned  output  1  access was split; valid with resp_valid.
REQ-013 SHALL have port: addr  output  32  data-memory address (registered).
REQ-014 SHALL have port: mem_mode  output  2  data-memory size (registered).
REQ-015 SHALL have port: mem_unsigned  output  1  data-memory extension select (registered).
REQ-016 SHALL have port: st_data  output  32  data-memory write data, right-justified (registered).
REQ-017 SHALL have port: st_en  output  1  data-memory write enable (registered).
REQ-018 SHALL have port: ld_data  input  32  data-memory read word, registered by the memory one edge after addr is presented.

Function
REQ-019 States SHALL be IDLE, RD0, RD1, RESP, ST; req_ready SHALL be high only in IDLE.
REQ-020 Misaligned: half with addr[1:0]=11, or word with addr[1:0]!=00; byte is never misaligned.
REQ-021 Loads SHALL always issue mem_mode=word, mem_unsigned=1, addr = word-aligned (req_addr & ~3); extraction and extension SHALL be done in the unit.
REQ-022 Accepted load: IDLE->RD0. Then RD0->RESP if aligned, or RD0->RD1 if misaligned, with addr advanced by +4 (mod 2^32).
REQ-023 In RD1: the unit SHALL capture ld_data (low word) into a buffer; transition RD1->RESP.
REQ-024 In RESP: resp_valid=1, and resp_rdata = bytes selected little-endian from ld_data (aligned) or {ld_data, buffer} (misaligned), then extended per req_mode/req_unsigned latched at accept; RESP->IDLE.
REQ-025 Load latency from the accept edge: resp_valid SHALL be high 2 cycles later if aligned, 3 cycles later if misaligned.
REQ-026 Aligned store: one ST cycle with st_en=1, addr=req_addr, mem_mode=req_mode, st_data=req_wdata; resp_valid SHALL be high in that same cycle; then ->IDLE.
REQ-027 Misaligned store: N byte writes (N=2 half, 4 word) in consecutive ST cycles; write k SHALL have addr=req_addr+k (mod 2^32), mem_mode=byte, st_data[7:0]=req_wdata[8k+7:8k] and upper bits 0. resp_valid SHALL be high in the final write cycle only.
REQ-028 st_en SHALL be low in every state except ST.
REQ-029 Request inputs SHALL be latched at accept; changes while busy SHALL be ignored.
REQ-030 Address wrap: 0xFFFFFFFE word load SHALL read words 0xFFFFFFFC and 0x00000000.

Reset
REQ-031 On reset: state=IDLE, all outputs 0 except req_ready=1, buffer and counter 0.
REQ-032 Reset mid-operation SHALL abandon the operation: no resp_valid, and st_en low from the reset edge on; remaining byte writes are dropped.

Structure
REQ-033 Package lsu_pkg SHALL hold the mode encodings (MODE_BYTE/HALF/WORD) and the state enumeration.
REQ-034 Sub-module load_align (combinational: byte offset, mode, unsigned, 64-bit window -> 32-bit result) SHALL implement extraction and extension.

Verification
REQ-035 LW 0x100, mem[0x100]=0xDEADBEEF -> addr=0x100, mode word; resp_valid at accept+2; rdata 0xDEADBEEF; misaligned=0.
REQ-036 LB 0x103 then LBU 0x103, word=0x80FF0011 -> rdata 0xFFFFFF80, then 0x00000080.
REQ-037 LW 0x102, mem[0x100]=0x44332211, mem[0x104]=0x88776655 -> reads 0x100 then 0x104; rdata 0x66554433 at accept+3; misaligned=1.
REQ-038 SH 0x103, wdata 0x0000BEEF -> st_en for 2 cycles: (0x103, 0xEF), then (0x104, 0xBE); resp_valid only in the second cycle.
REQ-039 Reset asserted in RD1 of a misaligned load -> no resp_valid, st_en=0, req_ready=1 after reset; the next LW 0x100 completes normally.
REQ-040 req_valid held high through a load -> exactly one accept per IDLE visit; a back-to-back second request is accepted in the cycle after RESP.
